mem_loader: RTL and testbench
=============================

# mem_loader

Stream-to-memory writer for the autoencoder weight/parameter memory. It accepts a narrow byte stream over a valid/ready handshake and packs the beats MSB-first into DATA_WIDTH words. It then drives the memory's synchronous write port (write_en / write_addr / write_data) to fill addresses 0..DEPTH-1 in order. It sits between the host/UART-side byte source and the dual-read-port parameter memory, which samples its write port on the falling clock edge.

## Interface
- ADDR_WIDTH, 4, memory address width
- DATA_WIDTH, 16, memory word width; must be an integer multiple of IN_WIDTH
- DEPTH, 9, number of words to load; DEPTH ≤ 2^ADDR_WIDTH
- IN_WIDTH, 8, stream beat width; BEATS = DATA_WIDTH/IN_WIDTH

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse, begins a load; ignored unless in IDLE
- in_valid  in  1  stream beat valid
- in_data  in  IN_WIDTH  stream beat
- in_ready  out  1  block accepts a beat this cycle
- write_en  out  1  memory write strobe, registered
- write_addr  out  ADDR_WIDTH  memory write address, registered
- write_data  out  DATA_WIDTH  memory write data, registered
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at load completion
- err  out  1  checksum mismatch flag (see Configuration)

## Operation
- States: IDLE, COLLECT, WRITE, CHECK (only with macro), DONE.
- IDLE: in_ready=0. start=1 → COLLECT; clears addr, beat counter, word shift register and checksum; clears err.
- COLLECT: in_ready=1. A beat is accepted when in_valid && in_ready; word = {word[DATA_WIDTH-IN_WIDTH-1:0], in_data}, so the first beat is the MSB. The BEATS-th accepted beat → WRITE. in_valid=0 stalls with no state change.
- WRITE: exactly one cycle; write_en=1, write_addr=addr, write_data=packed word; in_ready=0. The word is added to the checksum (mod 2^DATA_WIDTH). If addr==DEPTH-1 → CHECK (macro) or DONE; else addr+1 → COLLECT.
- CHECK: in_ready=1; collects BEATS more beats as the expected checksum (no memory write); on the last beat err ← (expected != running sum) → DONE.
- DONE: done=1 for one cycle → IDLE.
- write_addr and write_data hold their last values outside WRITE; write_en=0 outside WRITE.
- start while busy: ignored, with no effect on the load in progress.
- Reset (any time, including mid-load): state IDLE; in_ready, write_en, busy, done, err, write_addr, write_data all 0. Words already written stay in memory; the next start restarts at address 0.

## Timing
- All outputs are registered from clk rising edge; write_en is high for a full cycle, so the memory's falling-edge write samples stable address and data.
- Minimum cost per word is BEATS+1 cycles (BEATS accept cycles + 1 WRITE cycle).
- Fastest full load is DEPTH·(BEATS+1) cycles after start, +BEATS with the macro, then the DONE cycle. The done pulse follows the last WRITE/CHECK cycle by one cycle.
- The first in_ready=1 is in the cycle after start is sampled.
- err is valid from the done cycle and holds until the next start or reset.

## Configuration
- MEM_LOADER_CHECKSUM_EN defined:
  - CHECK state present; the stream carries DEPTH words followed by one checksum word.
  - err = 1 when that word differs from the mod-2^DATA_WIDTH sum of all written words.
  - done still pulses on mismatch.
  - Memory contents are not rolled back on mismatch.
- Not defined: no CHECK state, no checksum register, err tied to 0; the stream is exactly DEPTH words.

## Test plan
1. Reset: assert rst_n=0 mid-cycle → all outputs 0 asynchronously; busy=0 after release.
2. Defaults: start, then 18 bytes 0x00..0x11 with in_valid held high:
   - writes addr0=0x0001, addr1=0x0203 … addr8=0x1011;
   - write_en on every 3rd cycle;
   - one done pulse;
   - memory readback matches.
3. Same 18-byte stream with in_valid randomly deasserted → identical writes in the same order; no beat lost or duplicated; done once.
4. With MEM_LOADER_CHECKSUM_EN:
   - test 2 plus trailing bytes 0x48,0x51 → err=0;
   - trailing bytes 0x48,0x50 → err=1 with done pulsed;
   - next start clears err.
5. Reset after 4 words written → IDLE, outputs 0; a new start plus a full stream writes from addr 0 and completes normally.
6. start pulsed repeatedly during a load → no restart; addresses and done timing are unchanged versus test 2.

Source files
------------

// File: rtl/mem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : mem_loader
//  Purpose  : Packs a narrow valid/ready byte stream MSB-first into
//             DATA_WIDTH words and writes them to parameter memory
//             addresses 0..DEPTH-1 through a registered write port.
//  Options  : MEM_LOADER_CHECKSUM_EN - a trailing checksum word follows the
//             payload; err flags a mismatch with the sum of written words.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_loader #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 9,
    parameter int IN_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [IN_WIDTH-1:0]   in_data,
    output logic                  in_ready,
    output logic                  write_en,
    output logic [ADDR_WIDTH-1:0] write_addr,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int c_BEATS = DATA_WIDTH / IN_WIDTH;
    localparam int c_CNT_W = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_COLLECT = 3'd1;
    localparam logic [2:0] c_ST_WRITE   = 3'd2;
    localparam logic [2:0] c_ST_DONE    = 3'd3;
`ifdef MEM_LOADER_CHECKSUM_EN
    localparam logic [2:0] c_ST_CHECK   = 3'd4;
`endif

    logic [2:0]            r_state;
    logic [2:0]            w_state_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [c_CNT_W-1:0]    r_beat_cnt;
    logic [DATA_WIDTH-1:0] r_word;
    logic [DATA_WIDTH-1:0] w_word_next;
    logic                  w_accept;
    logic                  w_last_beat;
    logic                  w_last_addr;
    logic                  w_start_load;

    logic                  r_in_ready;
    logic                  r_write_en;
    logic [ADDR_WIDTH-1:0] r_write_addr;
    logic [DATA_WIDTH-1:0] r_write_data;
    logic                  r_busy;
    logic                  r_done;

    assign in_ready   = r_in_ready;
    assign write_en   = r_write_en;
    assign write_addr = r_write_addr;
    assign write_data = r_write_data;
    assign busy       = r_busy;
    assign done       = r_done;

    // in_ready is a registered copy of "state accepts beats", so it is exact
    assign w_accept     = in_valid && r_in_ready;
    assign w_last_beat  = (r_beat_cnt == c_CNT_W'(c_BEATS - 1));
    assign w_last_addr  = (r_addr == ADDR_WIDTH'(DEPTH - 1));
    assign w_start_load = (r_state == c_ST_IDLE) && start;

    // First beat ends up in the MSBs after BEATS shifts
    generate
        if (c_BEATS > 1) begin : g_shift
            assign w_word_next = {r_word[DATA_WIDTH-IN_WIDTH-1:0], in_data};
        end else begin : g_pass
            assign w_word_next = in_data;
        end
    endgenerate

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; start is only honoured from IDLE
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start) w_state_next = c_ST_COLLECT;
            end
            c_ST_COLLECT: begin
                if (w_accept && w_last_beat) w_state_next = c_ST_WRITE;
            end
            c_ST_WRITE: begin
                if (w_last_addr) begin
`ifdef MEM_LOADER_CHECKSUM_EN
                    w_state_next = c_ST_CHECK;
`else
                    w_state_next = c_ST_DONE;
`endif
                end else begin
                    w_state_next = c_ST_COLLECT;
                end
            end
`ifdef MEM_LOADER_CHECKSUM_EN
            c_ST_CHECK: begin
                if (w_accept && w_last_beat) w_state_next = c_ST_DONE;
            end
`endif
            c_ST_DONE: begin
                w_state_next = c_ST_IDLE;
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    // Status outputs registered from the next state so they line up with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_write_en <= 1'b0;
        end else begin
`ifdef MEM_LOADER_CHECKSUM_EN
            r_in_ready <= (w_state_next == c_ST_COLLECT) || (w_state_next == c_ST_CHECK);
`else
            r_in_ready <= (w_state_next == c_ST_COLLECT);
`endif
            r_busy     <= (w_state_next != c_ST_IDLE);
            r_done     <= (w_state_next == c_ST_DONE);
            r_write_en <= (w_state_next == c_ST_WRITE);
        end
    end

    // Beat packing and beat counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word     <= '0;
            r_beat_cnt <= '0;
        end else if (w_start_load) begin
            r_word     <= '0;
            r_beat_cnt <= '0;
        end else if (w_accept) begin
            r_word     <= w_word_next;
            r_beat_cnt <= w_last_beat ? '0 : r_beat_cnt + c_CNT_W'(1);
        end
    end

    // Address counter advances as each WRITE cycle retires
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= '0;
        end else if (w_start_load) begin
            r_addr <= '0;
        end else if ((r_state == c_ST_WRITE) && !w_last_addr) begin
            r_addr <= r_addr + ADDR_WIDTH'(1);
        end
    end

    // Write port address/data: loaded on entry to WRITE, held otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_write_addr <= '0;
            r_write_data <= '0;
        end else if ((r_state == c_ST_COLLECT) && w_accept && w_last_beat) begin
            r_write_addr <= r_addr;
            r_write_data <= w_word_next;
        end
    end

`ifdef MEM_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] r_sum;
    logic                  r_err;

    assign err = r_err;

    // Running mod-2^DATA_WIDTH sum of every word written this load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum <= '0;
        end else if (w_start_load) begin
            r_sum <= '0;
        end else if (r_state == c_ST_WRITE) begin
            r_sum <= r_sum + r_write_data;
        end
    end

    // Compare trailing checksum word on its last beat; sticky until next start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_start_load) begin
            r_err <= 1'b0;
        end else if ((r_state == c_ST_CHECK) && w_accept && w_last_beat) begin
            r_err <= (w_word_next != r_sum);
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_loader
//  Purpose  : Scoreboard bench for mem_loader; stimulus queues the expected
//             memory writes, a falling-edge monitor pops and compares them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_loader;

    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 9;
    localparam int IW    = 8;
    localparam int BEATS = DW / IW;
`ifdef MEM_LOADER_CHECKSUM_EN
    localparam int DONE_OFF = DEPTH * (BEATS + 1) + BEATS;
`else
    localparam int DONE_OFF = DEPTH * (BEATS + 1);
`endif

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          in_valid;
    logic [IW-1:0] in_data;
    logic          in_ready;
    logic          write_en;
    logic [AW-1:0] write_addr;
    logic [DW-1:0] write_data;
    logic          busy;
    logic          done;
    logic          err;

    mem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .IN_WIDTH(IW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .write_en(write_en),
        .write_addr(write_addr), .write_data(write_data), .busy(busy),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int            n_tests = 0;
    int            n_fail  = 0;
    int            cyc     = 0;
    int            t_start = 0;
    int            wcount  = 0;
    int            done_cnt = 0;
    bit            tchk    = 0;
    bit            feed_done = 0;
    logic          err_at_done = 1'b0;
    wr_t           exp_q[$];
    logic [IW-1:0] tb_bytes[$];
    logic [DW-1:0] exp_mem [DEPTH];
    logic [DW-1:0] mem     [2**AW];
    logic          exp_err = 1'b0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: memory model samples on the falling edge like the real memory
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (write_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_write: addr %0h data %0h with nothing expected",
                             write_addr, write_data);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("write_addr", 32'(write_addr), 32'(e.addr));
                    chk("write_data", 32'(write_data), 32'(e.data));
                    if (tchk) chk("write_cycle", 32'(cyc - t_start), 32'(3 * wcount + 2));
                end
                mem[write_addr] = write_data;
                wcount++;
            end
            if (done === 1'b1) begin
                done_cnt++;
                err_at_done = err;
                if (tchk) chk("done_cycle", 32'(cyc - t_start), 32'(DONE_OFF));
            end
        end
    end

    // Reference stream: words are either sequential bytes or random; the
    // optional checksum word is the plain sum, or deliberately off by one.
    task automatic build(input bit seq, input int csum_mode);
        logic [DW-1:0] w;
        logic [DW-1:0] sum;
        tb_bytes.delete();
        exp_q.delete();
        sum = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (seq) w = {8'(2 * i), 8'(2 * i + 1)};
            else     w = DW'($urandom);
            exp_mem[i] = w;
            exp_q.push_back('{addr: AW'(i), data: w});
            sum = sum + w;
            for (int b = BEATS - 1; b >= 0; b--) tb_bytes.push_back(w[b*IW +: IW]);
        end
        exp_err = 1'b0;
`ifdef MEM_LOADER_CHECKSUM_EN
        if (csum_mode != 0) begin
            if (seq) chk("model_sum", 32'(sum), 32'h4851);
            if (csum_mode == 2) begin
                sum = sum - 1;
                exp_err = 1'b1;
            end
            for (int b = BEATS - 1; b >= 0; b--) tb_bytes.push_back(sum[b*IW +: IW]);
        end
`endif
    endtask

    task automatic do_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        t_start = cyc;
    endtask

    // Feeds up to n bytes of tb_bytes; gap_pct is the chance of idling a cycle
    task automatic feed(input int n, input int gap_pct);
        int   idx;
        int   guard;
        logic rdy;
        idx   = 0;
        guard = 0;
        while (idx < n) begin
            #1;
            in_valid = ($urandom_range(0, 99) >= gap_pct);
            in_data  = in_valid ? tb_bytes[idx] : IW'($urandom);
            @(negedge clk) rdy = in_ready;
            @(posedge clk);
            if (in_valid && rdy) idx++;
            guard++;
            if (guard > 2000) begin
                chk("feed_timeout", 32'(idx), 32'(n));
                break;
            end
        end
        feed_done = 1;
        #1 in_valid = 1'b0;
    endtask

    task automatic pulse_starts();
        while (!feed_done) begin
            @(posedge clk);
            #1;
            start = feed_done ? 1'b0 : 1'($urandom_range(0, 1));
        end
        start = 1'b0;
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 200; i++) begin
            if (done_cnt >= target) break;
            @(posedge clk);
        end
        repeat (4) @(posedge clk);
        chk("done_count", 32'(done_cnt), 32'(target));
    endtask

    task automatic readback();
        for (int i = 0; i < DEPTH; i++) chk("readback", 32'(mem[i]), 32'(exp_mem[i]));
    endtask

    task automatic run_load(input bit seq, input int csum_mode, input int gap_pct,
                            input bit timing, input bit start_noise);
        build(seq, csum_mode);
        wcount    = 0;
        done_cnt  = 0;
        feed_done = 0;
        for (int i = 0; i < 2**AW; i++) mem[i] = 'x;
        do_start();
        tchk = timing;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("err_cleared", 32'(err), 32'd0);
        if (start_noise) begin
            fork
                feed(tb_bytes.size(), gap_pct);
                pulse_starts();
            join
        end else begin
            feed(tb_bytes.size(), gap_pct);
        end
        wait_done(1);
        tchk = 0;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("write_count", 32'(wcount), 32'(DEPTH));
        chk("busy_idle", 32'(busy), 32'd0);
        readback();
`ifdef MEM_LOADER_CHECKSUM_EN
        if (csum_mode != 0) begin
            chk("err_at_done", 32'(err_at_done), 32'(exp_err));
            chk("err_held", 32'(err), 32'(exp_err));
        end
`endif
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_in_ready"},   32'(in_ready),   32'd0);
        chk({tag, "_write_en"},   32'(write_en),   32'd0);
        chk({tag, "_write_addr"}, 32'(write_addr), 32'd0);
        chk({tag, "_write_data"}, 32'(write_data), 32'd0);
        chk({tag, "_busy"},       32'(busy),       32'd0);
        chk({tag, "_done"},       32'(done),       32'd0);
        chk({tag, "_err"},        32'(err),        32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        #1;
        chk_outputs_zero("reset");
        #22 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk("busy_after_release", 32'(busy), 32'd0);

        // Sequential bytes, no gaps, exact cycle timing
        run_load(1'b1, 1, 0, 1'b1, 1'b0);
        chk("addr0_word", 32'(mem[0]), 32'h0001);
        chk("addr8_word", 32'(mem[8]), 32'h1011);

        // Same stream with random stalls, then random data with stalls
        run_load(1'b1, 1, 40, 1'b0, 1'b0);
        for (int r = 0; r < 3; r++) run_load(1'b0, 1, 30, 1'b0, 1'b0);

`ifdef MEM_LOADER_CHECKSUM_EN
        // Wrong checksum, then a good load clears err at the next start
        run_load(1'b1, 2, 0, 1'b1, 1'b0);
        run_load(1'b0, 2, 25, 1'b0, 1'b0);
        run_load(1'b1, 1, 0, 1'b1, 1'b0);
`endif

        // Reset after four words have been written
        build(1'b1, 1);
        wcount   = 0;
        done_cnt = 0;
        feed_done = 0;
        do_start();
        feed(4 * BEATS, 0);
        repeat (3) @(posedge clk);
        chk("partial_writes", 32'(wcount), 32'd4);
        #3 rst_n = 1'b0;
        #1 chk_outputs_zero("midreset");
        exp_q.delete();
        @(negedge clk) rst_n = 1'b1;
        chk("midreset_no_done", 32'(done_cnt), 32'd0);
        run_load(1'b1, 1, 0, 1'b1, 1'b0);

        // Start pulses during a load must not disturb it
        run_load(1'b1, 1, 0, 1'b1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
